// File: rtl/cache_pkg.sv
// Shared cache types: access opcodes, LRU tracker states and tick helpers.
package cache_pkg;

   localparam int CACHE_S = 64;
   localparam int CACHE_E = 4;
   localparam int TICK_WIDTH = 32;

   typedef logic [TICK_WIDTH-1:0] tick_t;

   localparam tick_t TICK_MAX = '1;

   typedef enum logic {
      ACC_TOUCH      = 1'b0,
      ACC_INVALIDATE = 1'b1
   } acc_op_t;

   typedef enum logic {
      LRU_RUN    = 1'b0,
      LRU_RENORM = 1'b1
   } lru_state_t;

endpackage

// File: rtl/lru_tick_set.sv
// Tick registers for the lines of one set, with a write port and a
// halving strobe used by the renormalisation pass.
module lru_tick_set #(
   parameter int SET_SIZE   = 4,
   parameter int TICK_WIDTH = 32,
   parameter int KEY_WIDTH  = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 we,
   input  logic [KEY_WIDTH-1:0]                 line,
   input  logic [TICK_WIDTH-1:0]                value,
   input  logic                                 halve,
   output logic [SET_SIZE-1:0][TICK_WIDTH-1:0]  ticks
);

   logic [SET_SIZE-1:0][TICK_WIDTH-1:0] ticks_q, ticks_d;

   always_comb begin
      ticks_d = ticks_q;
      for (int i = 0; i < SET_SIZE; i++) begin
         // halve but never let a valid tick collapse to the invalid value 0
         if (halve && ticks_q[i] > TICK_WIDTH'(1)) begin
            ticks_d[i] = ticks_q[i] >> 1;
         end
         if (we && line == KEY_WIDTH'(i)) begin
            ticks_d[i] = value;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ticks_q <= '0;
      end else begin
         ticks_q <= ticks_d;
      end
   end

   assign ticks = ticks_q;

endmodule

// File: rtl/lru_tick_tracker.sv
// Global access counter, per-line LRU tick stamping and the
// wrap-around renormalisation FSM.
module lru_tick_tracker
   import cache_pkg::*;
#(
   parameter int NUM_SETS   = CACHE_S,
   parameter int SET_SIZE   = CACHE_E,
   parameter int TICK_WIDTH = 32,
   parameter int _SET_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
   parameter int _KEY_WIDTH = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 acc_valid,
   output logic                                 acc_ready,
   input  logic                                 acc_op,
   input  logic [_SET_WIDTH-1:0]                acc_set,
   input  logic [_KEY_WIDTH-1:0]                acc_line,
   input  logic [_SET_WIDTH-1:0]                query_set,
   output logic [SET_SIZE-1:0][TICK_WIDTH-1:0]  tick,
   output logic                                 busy
);

   localparam logic [TICK_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [_SET_WIDTH:0]   NSETS    = (_SET_WIDTH+1)'(NUM_SETS);
   localparam logic [_SET_WIDTH-1:0] LAST_SET = _SET_WIDTH'(NUM_SETS - 1);

   lru_state_t state_q, state_d;
   logic [TICK_WIDTH-1:0] cnt_q, cnt_d;
   logic [_SET_WIDTH-1:0] k_q, k_d;
   logic accept;
   logic [TICK_WIDTH-1:0] wr_val;

   logic [SET_SIZE-1:0][TICK_WIDTH-1:0] set_ticks [NUM_SETS];

   assign acc_ready = (state_q == LRU_RUN);
   assign busy      = ~acc_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      accept  = acc_valid && acc_ready && ({1'b0, acc_set} < NSETS);
      wr_val  = (acc_op == ACC_INVALIDATE) ? '0 : cnt_q;
      unique case (state_q)
         LRU_RUN: begin
            if (accept && acc_op == ACC_TOUCH) begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end else begin
                  state_d = LRU_RENORM;
                  k_d     = '0;
               end
            end
         end
         LRU_RENORM: begin
            k_d = k_q + 1'b1;
            if (k_q == LAST_SET) begin
               cnt_d   = (cnt_q >> 1) + 1'b1;
               state_d = LRU_RUN;
               k_d     = '0;
            end
         end
         default: state_d = LRU_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LRU_RUN;
         cnt_q   <= TICK_WIDTH'(1);
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
      end
   end

   for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
      lru_tick_set #(
         .SET_SIZE   (SET_SIZE),
         .TICK_WIDTH (TICK_WIDTH),
         .KEY_WIDTH  (_KEY_WIDTH)
      ) u_set (
         .clk   (clk),
         .reset (reset),
         .we    (accept && acc_set == _SET_WIDTH'(s)),
         .line  (acc_line),
         .value (wr_val),
         .halve (state_q == LRU_RENORM && k_q == _SET_WIDTH'(s)),
         .ticks (set_ticks[s])
      );
   end

   // out-of-range query sets read as all-invalid
   always_comb begin
      tick = '0;
      for (int s = 0; s < NUM_SETS; s++) begin
         if (query_set == _SET_WIDTH'(s)) begin
            tick = set_ticks[s];
         end
      end
   end

endmodule

// File: tb/tb_lru_tick_tracker.sv
// Directed bench for lru_tick_tracker: stamping, invalidate,
// wrap-around renormalisation and reset during the pass.
module tb_lru_tick_tracker;

   logic clk = 1'b0;
   logic reset;
   logic acc_valid;
   logic acc_ready;
   logic acc_op;
   logic [0:0] acc_set;
   logic [1:0] acc_line;
   logic [0:0] query_set;
   logic [3:0][3:0] tick;
   logic busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lru_tick_tracker #(
      .NUM_SETS   (2),
      .SET_SIZE   (4),
      .TICK_WIDTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .acc_valid (acc_valid),
      .acc_ready (acc_ready),
      .acc_op    (acc_op),
      .acc_set   (acc_set),
      .acc_line  (acc_line),
      .query_set (query_set),
      .tick      (tick),
      .busy      (busy)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_set(input string tag, input int s,
                          input int e0, input int e1,
                          input int e2, input int e3);
      query_set = 1'(s);
      #1;
      chk({tag, "_l0"}, int'(tick[0]), e0);
      chk({tag, "_l1"}, int'(tick[1]), e1);
      chk({tag, "_l2"}, int'(tick[2]), e2);
      chk({tag, "_l3"}, int'(tick[3]), e3);
   endtask

   task automatic access(input logic op, input int s, input int l);
      acc_valid = 1'b1;
      acc_op    = op;
      acc_set   = 1'(s);
      acc_line  = 2'(l);
      @(posedge clk);
      #1;
      acc_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      acc_valid = 1'b0;
      acc_op    = 1'b0;
      acc_set   = '0;
      acc_line  = '0;
      query_set = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // reset state
      chk_set("rst_s0", 0, 0, 0, 0, 0);
      chk_set("rst_s1", 1, 0, 0, 0, 0);
      chk("rst_ready", int'(acc_ready), 1);
      chk("rst_busy", int'(busy), 0);

      // basic stamping
      access(1'b0, 0, 2);
      access(1'b0, 0, 0);
      access(1'b0, 0, 3);
      chk_set("stamp_s0", 0, 2, 0, 1, 3);

      // invalidate leaves the counter alone
      access(1'b1, 0, 0);
      chk_set("inv_s0", 0, 0, 0, 1, 3);
      access(1'b0, 0, 1);
      chk_set("inv_touch_s0", 0, 0, 4, 1, 3);

      // run the counter up to 15
      for (int i = 5; i <= 13; i++) access(1'b0, 1, 3);
      access(1'b0, 1, 1);
      access(1'b0, 1, 0);
      chk_set("pre_wrap_s1", 1, 15, 14, 0, 13);
      chk("wrap_ready_c0", int'(acc_ready), 0);
      chk("wrap_busy_c0", int'(busy), 1);

      // request held through the renormalisation pass
      acc_valid = 1'b1;
      acc_op    = 1'b0;
      acc_set   = 1'b0;
      acc_line  = 2'd0;
      @(posedge clk);
      #1;
      chk("wrap_ready_c1", int'(acc_ready), 0);
      @(posedge clk);
      #1;
      chk("wrap_ready_c2", int'(acc_ready), 1);
      chk_set("post_wrap_s1", 1, 7, 7, 0, 6);
      chk_set("post_wrap_s0", 0, 0, 2, 1, 1);
      @(posedge clk);
      #1;
      acc_valid = 1'b0;
      chk_set("held_req_s0", 0, 8, 2, 1, 1);
      access(1'b0, 1, 2);
      chk_set("after_held_s1", 1, 7, 7, 9, 6);

      // second wrap, then reset in the first RENORM cycle
      for (int i = 10; i <= 15; i++) access(1'b0, 0, 1);
      chk_set("pre_wrap2_s0", 0, 8, 15, 1, 1);
      chk("wrap2_ready", int'(acc_ready), 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst_ready", int'(acc_ready), 1);
      chk("midrst_busy", int'(busy), 0);
      chk_set("midrst_s0", 0, 0, 0, 0, 0);
      chk_set("midrst_s1", 1, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("midrst_idle_ready", int'(acc_ready), 1);
      access(1'b0, 0, 3);
      chk_set("midrst_touch_s0", 0, 0, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
